// File: rtl/multimode_watch_if.sv
// multimode_watch_if: control inputs and status outputs of the watch core.
//   master: drives the buttons, set values and alarm configuration, and observes status.
//   slave : the watch core itself.
//   Inputs : mode_btn, set_hours/minutes/load, alarm_hours/minutes/en (packed per channel),
//            snooze, alarm_off, sw_start_stop, sw_lap, sw_reset.
//   Outputs: second/minute/hour_count, mode, tick, alarm_active/flash/id,
//            sw_seconds, sw_lap_value.
interface multimode_watch_if #(
    parameter int unsigned N_ALARMS = 2
);
    localparam int unsigned AW = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1;

    logic                    mode_btn;
    logic [4:0]              set_hours;
    logic [5:0]              set_minutes;
    logic                    set_load;
    logic [5*N_ALARMS-1:0]   alarm_hours;
    logic [6*N_ALARMS-1:0]   alarm_minutes;
    logic [N_ALARMS-1:0]     alarm_en;
    logic                    snooze;
    logic                    alarm_off;
    logic                    sw_start_stop;
    logic                    sw_lap;
    logic                    sw_reset;

    logic [5:0]              second_count;
    logic [5:0]              minute_count;
    logic [4:0]              hour_count;
    logic [1:0]              mode;
    logic                    tick;
    logic                    alarm_active;
    logic                    alarm_flash;
    logic [AW-1:0]           alarm_id;
    logic [6:0]              sw_seconds;
    logic [6:0]              sw_lap_value;

    modport master (
        output mode_btn, set_hours, set_minutes, set_load, alarm_hours, alarm_minutes,
               alarm_en, snooze, alarm_off, sw_start_stop, sw_lap, sw_reset,
        input  second_count, minute_count, hour_count, mode, tick, alarm_active,
               alarm_flash, alarm_id, sw_seconds, sw_lap_value
    );

    modport slave (
        input  mode_btn, set_hours, set_minutes, set_load, alarm_hours, alarm_minutes,
               alarm_en, snooze, alarm_off, sw_start_stop, sw_lap, sw_reset,
        output second_count, minute_count, hour_count, mode, tick, alarm_active,
               alarm_flash, alarm_id, sw_seconds, sw_lap_value
    );
endinterface

// File: rtl/multimode_watch.sv
// multimode_watch: 24-hour clock with set mode, N alarms (flash, snooze, auto-off) and a
// wrapping stopwatch with lap capture. All counts are binary.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : multimode_watch_if.slave (buttons/config in, time/alarm/stopwatch status out)
module multimode_watch #(
    parameter int unsigned TICK_DIV   = 50_000_000,
    parameter int unsigned N_ALARMS   = 2,
    parameter int unsigned SNOOZE_MIN = 5,
    parameter int unsigned ALARM_SEC  = 60,
    parameter int unsigned SW_MAX     = 99
) (
    input  logic              clk,
    input  logic              reset,
    multimode_watch_if.slave  bus
);
    localparam int unsigned AW        = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1;
    localparam int unsigned DW        = $clog2(TICK_DIV);
    localparam int unsigned SNZ_TICKS = SNOOZE_MIN * 60;
    localparam int unsigned SNZW      = $clog2(SNZ_TICKS + 1);

    typedef enum logic [1:0] {
        StClock     = 2'd0,
        StSet       = 2'd1,
        StStopwatch = 2'd2
    } mode_e;

    mode_e mode_q, mode_d;
    logic  time_run, set_mode, sw_mode;

    logic [DW-1:0] div_q, div_d;
    logic          tick;

    logic [5:0] sec_q, sec_d, min_q, min_d;
    logic [4:0] hr_q, hr_d;
    logic       time_adv, load_ok;

    logic          match_any, alarm_hit;
    logic [AW-1:0] match_idx;

    logic            act_q, act_d, flash_q, flash_d, pend_q, pend_d;
    logic [AW-1:0]   id_q, id_d;
    logic [7:0]      dur_q, dur_d;
    logic [SNZW-1:0] snz_q, snz_d;

    logic       sw_run_q, sw_run_d;
    logic [6:0] sw_cnt_q, sw_cnt_d, sw_lap_q, sw_lap_d;

    // Seconds strobe straight off the divider register.
    assign tick = (div_q == DW'(TICK_DIV - 1));

    // ---------------- mode FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) mode_q <= StClock;
        else       mode_q <= mode_d;
    end

    always_comb begin
        mode_d = mode_q;
        case (mode_q)
            StClock:     if (bus.mode_btn) mode_d = StSet;
            StSet:       if (bus.mode_btn) mode_d = StStopwatch;
            StStopwatch: if (bus.mode_btn) mode_d = StClock;
            default:     mode_d = StClock;  // unreachable code 3 recovers
        endcase
    end

    always_comb begin
        bus.mode = mode_q;
        time_run = (mode_q != StSet);
        set_mode = (mode_q == StSet);
        sw_mode  = (mode_q == StStopwatch);
    end

    // ---------------- divider and time of day ----------------
    always_comb begin
        time_adv = tick && time_run;
        load_ok  = bus.set_load && set_mode && (bus.set_hours <= 5'd23)
                   && (bus.set_minutes <= 6'd59);
        div_d = tick ? '0 : div_q + 1'b1;
        sec_d = sec_q;
        min_d = min_q;
        hr_d  = hr_q;
        if (load_ok) begin
            hr_d  = bus.set_hours;
            min_d = bus.set_minutes;
            sec_d = '0;
            div_d = '0;
        end else if (time_adv) begin
            if (sec_q == 6'd59) begin
                sec_d = '0;
                if (min_q == 6'd59) begin
                    min_d = '0;
                    hr_d  = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
                end else begin
                    min_d = min_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end
    end

    // Match against the next-time value; only a ticking advance can fire, not a load.
    always_comb begin
        match_any = 1'b0;
        match_idx = '0;
        for (int i = int'(N_ALARMS) - 1; i >= 0; i--) begin
            if (bus.alarm_en[i] && (bus.alarm_hours[5*i +: 5] == hr_d)
                && (bus.alarm_minutes[6*i +: 6] == min_d)) begin
                match_any = 1'b1;
                match_idx = AW'(i);
            end
        end
        alarm_hit = time_adv && (sec_d == 6'd0) && match_any;
    end

    // ---------------- alarm / snooze ----------------
    always_comb begin
        act_d   = act_q;
        flash_d = flash_q;
        id_d    = id_q;
        dur_d   = dur_q;
        pend_d  = pend_q;
        snz_d   = snz_q;
        if (bus.alarm_off) begin
            act_d   = 1'b0;
            flash_d = 1'b0;
            pend_d  = 1'b0;
        end else if (bus.snooze && act_q) begin
            act_d   = 1'b0;
            flash_d = 1'b0;
            pend_d  = 1'b1;
            snz_d   = SNZW'(SNZ_TICKS);
        end else if (act_q) begin
            if (tick) begin
                flash_d = ~flash_q;
                dur_d   = dur_q + 8'd1;
                if (dur_q == 8'(ALARM_SEC - 1)) begin
                    act_d   = 1'b0;
                    flash_d = 1'b0;
                end
            end
        end else if (alarm_hit) begin
            act_d   = 1'b1;
            flash_d = 1'b1;
            id_d    = match_idx;
            dur_d   = '0;
            pend_d  = 1'b0;
        end else if (pend_q && tick) begin
            snz_d = snz_q - 1'b1;
            if (snz_q == SNZW'(1)) begin
                // re-fire keeps the stored id
                act_d   = 1'b1;
                flash_d = 1'b1;
                dur_d   = '0;
                pend_d  = 1'b0;
            end
        end
    end

    // ---------------- stopwatch ----------------
    always_comb begin
        sw_run_d = sw_run_q;
        sw_cnt_d = sw_cnt_q;
        sw_lap_d = sw_lap_q;
        if (bus.sw_reset) begin
            sw_run_d = 1'b0;
            sw_cnt_d = '0;
            sw_lap_d = '0;
        end else begin
            // increment uses the pre-edge run state even if toggled this cycle
            if (tick && sw_run_q) begin
                sw_cnt_d = (sw_cnt_q == 7'(SW_MAX)) ? 7'd0 : sw_cnt_q + 7'd1;
            end
            if (sw_mode && bus.sw_start_stop) sw_run_d = ~sw_run_q;
            if (sw_mode && bus.sw_lap)        sw_lap_d = sw_cnt_q;
        end
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q    <= '0;
            sec_q    <= '0;
            min_q    <= '0;
            hr_q     <= '0;
            act_q    <= 1'b0;
            flash_q  <= 1'b0;
            id_q     <= '0;
            dur_q    <= '0;
            pend_q   <= 1'b0;
            snz_q    <= '0;
            sw_run_q <= 1'b0;
            sw_cnt_q <= '0;
            sw_lap_q <= '0;
        end else begin
            div_q    <= div_d;
            sec_q    <= sec_d;
            min_q    <= min_d;
            hr_q     <= hr_d;
            act_q    <= act_d;
            flash_q  <= flash_d;
            id_q     <= id_d;
            dur_q    <= dur_d;
            pend_q   <= pend_d;
            snz_q    <= snz_d;
            sw_run_q <= sw_run_d;
            sw_cnt_q <= sw_cnt_d;
            sw_lap_q <= sw_lap_d;
        end
    end

    assign bus.tick         = tick;
    assign bus.second_count = sec_q;
    assign bus.minute_count = min_q;
    assign bus.hour_count   = hr_q;
    assign bus.alarm_active = act_q;
    assign bus.alarm_flash  = flash_q;
    assign bus.alarm_id     = id_q;
    assign bus.sw_seconds   = sw_cnt_q;
    assign bus.sw_lap_value = sw_lap_q;
endmodule

// File: tb/tb_multimode_watch.sv
// Bench for multimode_watch: directed scenarios then randomized pulses, every cycle checked
// against a time-of-day-in-seconds reference model.
module tb_multimode_watch;
    localparam int TD  = 4;
    localparam int NA  = 2;
    localparam int SM  = 1;
    localparam int AS  = 6;
    localparam int SWM = 9;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    multimode_watch_if #(.N_ALARMS(NA)) bus ();

    multimode_watch #(
        .TICK_DIV   (TD),
        .N_ALARMS   (NA),
        .SNOOZE_MIN (SM),
        .ALARM_SEC  (AS),
        .SW_MAX     (SWM)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // stimulus shadows
    bit p_mode, p_load, p_snz, p_off, p_ss, p_lap, p_swr;
    int sh, sm;
    int a_h [NA];
    int a_m [NA];
    bit a_en [NA];

    // reference model: time as seconds of day
    int m_div, m_t, m_mode, m_id, m_dur, m_snz, m_sw, m_lap;
    bit m_act, m_flash, m_pend, m_run;

    int n_checks = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive();
        bus.mode_btn      = p_mode;
        bus.set_hours     = 5'(sh);
        bus.set_minutes   = 6'(sm);
        bus.set_load      = p_load;
        bus.snooze        = p_snz;
        bus.alarm_off     = p_off;
        bus.sw_start_stop = p_ss;
        bus.sw_lap        = p_lap;
        bus.sw_reset      = p_swr;
        for (int i = 0; i < NA; i++) begin
            bus.alarm_hours[5*i +: 5]   = 5'(a_h[i]);
            bus.alarm_minutes[6*i +: 6] = 6'(a_m[i]);
            bus.alarm_en[i]             = a_en[i];
        end
    endtask

    // One clock: apply shadows, predict, advance, compare every output.
    task automatic step();
        bit t, adv, ld, hit;
        int tn, divn, moden, hid;
        int n_id, n_dur, n_snz, n_sw, n_lap;
        bit n_act, n_flash, n_pend, n_run;
        drive();
        t = (m_div == TD - 1);
        if (!reset) check("tick", 32'(bus.tick), 32'(t));
        n_act = m_act; n_flash = m_flash; n_id = m_id; n_dur = m_dur;
        n_pend = m_pend; n_snz = m_snz; n_run = m_run; n_sw = m_sw; n_lap = m_lap;
        tn = m_t; moden = m_mode;
        divn = t ? 0 : m_div + 1;
        if (reset) begin
            tn = 0; divn = 0; moden = 0;
            n_act = 0; n_flash = 0; n_id = 0; n_dur = 0; n_pend = 0; n_snz = 0;
            n_run = 0; n_sw = 0; n_lap = 0;
        end else begin
            adv = t && (m_mode != 1);
            ld = p_load && (m_mode == 1) && (sh < 24) && (sm < 60);
            if (ld) begin
                tn = sh * 3600 + sm * 60;
                divn = 0;
            end else if (adv) begin
                tn = (m_t + 1) % 86400;
            end
            if (p_mode) moden = (m_mode + 1) % 3;
            hit = 0; hid = 0;
            if (adv && (tn % 60 == 0)) begin
                for (int i = NA - 1; i >= 0; i--) begin
                    if (a_en[i] && (a_h[i] * 60 + a_m[i] == tn / 60)) begin
                        hit = 1; hid = i;
                    end
                end
            end
            if (p_off) begin
                n_act = 0; n_flash = 0; n_pend = 0;
            end else if (p_snz && m_act) begin
                n_act = 0; n_flash = 0; n_pend = 1; n_snz = SM * 60;
            end else if (m_act) begin
                if (t) begin
                    n_flash = !m_flash;
                    n_dur = m_dur + 1;
                    if (n_dur == AS) begin n_act = 0; n_flash = 0; end
                end
            end else if (hit) begin
                n_act = 1; n_flash = 1; n_id = hid; n_dur = 0; n_pend = 0;
            end else if (m_pend && t) begin
                n_snz = m_snz - 1;
                if (n_snz == 0) begin n_act = 1; n_flash = 1; n_dur = 0; n_pend = 0; end
            end
            if (p_swr) begin
                n_run = 0; n_sw = 0; n_lap = 0;
            end else begin
                if (t && m_run) n_sw = (m_sw + 1) % (SWM + 1);
                if (m_mode == 2 && p_ss) n_run = !m_run;
                if (m_mode == 2 && p_lap) n_lap = m_sw;
            end
        end
        @(posedge clk);
        #1;
        m_t = tn; m_div = divn; m_mode = moden;
        m_act = n_act; m_flash = n_flash; m_id = n_id; m_dur = n_dur;
        m_pend = n_pend; m_snz = n_snz; m_run = n_run; m_sw = n_sw; m_lap = n_lap;
        check("second_count", 32'(bus.second_count), 32'(m_t % 60));
        check("minute_count", 32'(bus.minute_count), 32'((m_t / 60) % 60));
        check("hour_count", 32'(bus.hour_count), 32'(m_t / 3600));
        check("mode", 32'(bus.mode), 32'(m_mode));
        check("alarm_active", 32'(bus.alarm_active), 32'(m_act));
        check("alarm_flash", 32'(bus.alarm_flash), 32'(m_flash));
        check("alarm_id", 32'(bus.alarm_id), 32'(m_id));
        check("sw_seconds", 32'(bus.sw_seconds), 32'(m_sw));
        check("sw_lap_value", 32'(bus.sw_lap_value), 32'(m_lap));
        p_mode = 0; p_load = 0; p_snz = 0; p_off = 0; p_ss = 0; p_lap = 0; p_swr = 0;
    endtask

    task automatic run_ticks(input int n);
        int c = 0;
        while (c < n) begin
            if (m_div == TD - 1) c++;
            step();
        end
    endtask

    initial begin
        int nrand;
        sh = 0; sm = 0;
        for (int i = 0; i < NA; i++) begin a_h[i] = 0; a_m[i] = 0; a_en[i] = 0; end
        m_div = 0; m_t = 0; m_mode = 0; m_id = 0; m_dur = 0; m_snz = 0; m_sw = 0; m_lap = 0;
        m_act = 0; m_flash = 0; m_pend = 0; m_run = 0;

        // reset
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        check("rst_mode", 32'(bus.mode), 32'd0);
        check("rst_sec", 32'(bus.second_count), 32'd0);
        check("rst_alarm", 32'(bus.alarm_active), 32'd0);
        check("rst_sw", 32'(bus.sw_seconds), 32'd0);

        // one minute of free running
        for (int k = 0; k < 240; k++) step();
        check("wrap_sec", 32'(bus.second_count), 32'd0);
        check("wrap_min", 32'(bus.minute_count), 32'd1);

        // 23:59 then day wrap while in stopwatch mode
        p_mode = 1; step();
        sh = 23; sm = 59; p_load = 1; step();
        p_mode = 1; step();
        run_ticks(61);
        check("daywrap_hr", 32'(bus.hour_count), 32'd0);
        check("daywrap_min", 32'(bus.minute_count), 32'd0);
        check("daywrap_sec", 32'(bus.second_count), 32'd1);

        // invalid load ignored, valid load restarts divider
        p_mode = 1; step();
        p_mode = 1; step();
        check("in_set", 32'(bus.mode), 32'd1);
        sh = 24; sm = 10; p_load = 1; step();
        check("badload_hr", 32'(bus.hour_count), 32'd0);
        check("badload_min", 32'(bus.minute_count), 32'd0);
        sh = 7; sm = 15; p_load = 1; step();
        check("load_hr", 32'(bus.hour_count), 32'd7);
        check("load_min", 32'(bus.minute_count), 32'd15);
        check("load_sec", 32'(bus.second_count), 32'd0);
        check("div_restart", 32'(bus.tick), 32'd0);
        step(); step(); step();
        check("div_tick", 32'(bus.tick), 32'd1);

        // two alarms at 07:16, lowest index wins, flash and auto-off
        a_h[0] = 7; a_m[0] = 16; a_en[0] = 1;
        a_h[1] = 7; a_m[1] = 16; a_en[1] = 1;
        p_mode = 1; step();
        run_ticks(60);
        check("match_active", 32'(bus.alarm_active), 32'd1);
        check("match_id", 32'(bus.alarm_id), 32'd0);
        check("match_flash", 32'(bus.alarm_flash), 32'd1);
        run_ticks(1);
        check("flash_toggle", 32'(bus.alarm_flash), 32'd0);
        run_ticks(AS - 2);
        check("still_active", 32'(bus.alarm_active), 32'd1);
        run_ticks(1);
        check("auto_off", 32'(bus.alarm_active), 32'd0);

        // snooze on channel 1
        a_en[0] = 0; a_m[1] = 17;
        for (int k = 0; k < 400 && !m_act; k++) step();
        check("ch1_fire", 32'(bus.alarm_active), 32'd1);
        check("ch1_id", 32'(bus.alarm_id), 32'd1);
        p_snz = 1; step();
        check("snoozed", 32'(bus.alarm_active), 32'd0);
        run_ticks(SM * 60 - 1);
        check("snooze_wait", 32'(bus.alarm_active), 32'd0);
        run_ticks(1);
        check("snooze_refire", 32'(bus.alarm_active), 32'd1);
        check("snooze_id", 32'(bus.alarm_id), 32'd1);
        p_off = 1; p_snz = 1; step();
        check("off_wins", 32'(bus.alarm_active), 32'd0);
        run_ticks(70);
        check("nothing_pending", 32'(bus.alarm_active), 32'd0);

        // stopwatch
        check("sw_mode", 32'(bus.mode), 32'd2);
        p_ss = 1; step();
        run_ticks(12);
        check("sw_wrap", 32'(bus.sw_seconds), 32'd2);
        p_lap = 1; step();
        check("sw_lap", 32'(bus.sw_lap_value), 32'd2);
        p_swr = 1; p_ss = 1; step();
        check("swr_cnt", 32'(bus.sw_seconds), 32'd0);
        check("swr_lap", 32'(bus.sw_lap_value), 32'd0);
        run_ticks(5);
        check("swr_stopped", 32'(bus.sw_seconds), 32'd0);

        // randomized phase
        for (int it = 0; it < 16; it++) begin
            for (int k = 0; k < 3 && m_mode != 1; k++) begin p_mode = 1; step(); end
            sh = int'($urandom_range(0, 23));
            sm = int'($urandom_range(0, 58));
            p_load = 1; step();
            a_h[0] = sh; a_m[0] = sm + 1;
            a_h[1] = ($urandom_range(0, 1) == 0) ? sh : int'($urandom_range(0, 23));
            a_m[1] = int'($urandom_range(0, 1)) + sm + 1;
            a_en[0] = bit'($urandom_range(0, 1));
            a_en[1] = bit'($urandom_range(0, 1));
            nrand = int'($urandom_range(1, 2));
            for (int k = 0; k < nrand; k++) begin p_mode = 1; step(); end
            for (int k = 0; k < 900; k++) begin
                p_snz  = ($urandom_range(0, 149) == 0);
                p_off  = ($urandom_range(0, 399) == 0);
                p_ss   = ($urandom_range(0, 99) == 0);
                p_lap  = ($urandom_range(0, 49) == 0);
                p_swr  = ($urandom_range(0, 499) == 0);
                p_mode = ($urandom_range(0, 599) == 0);
                p_load = ($urandom_range(0, 299) == 0);
                if (p_load) begin
                    sh = int'($urandom_range(0, 31));
                    sm = int'($urandom_range(0, 63));
                end
                reset = ($urandom_range(0, 2999) == 0);
                step();
                reset = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule
